// File: rtl/i2s_frame_sequencer_if.sv
// Sample-pair stream from the RPi receiver into the I2S frame sequencer.
// The master offers a left/right pair; the slave accepts it when s_ready is high.
interface i2s_frame_sequencer_if #(
    parameter int SAMPLE_W = 24
);
    logic                s_valid;
    logic                s_ready;
    logic [SAMPLE_W-1:0] s_left;
    logic [SAMPLE_W-1:0] s_right;

    modport master (output s_valid, output s_left, output s_right, input s_ready);
    modport slave  (input s_valid, input s_left, input s_right, output s_ready);
endinterface

// File: rtl/i2s_frame_sequencer.sv
// Stereo I2S transmit sequencer: one-pair buffer, bclk/lrclk generation, MSB-first
// slot shifters reloaded at each frame boundary, zero frames and a counter on underrun.
module i2s_frame_sequencer #(
    parameter int SAMPLE_W = 24,
    parameter int SLOT_W   = 32,
    parameter int BCLK_DIV = 4,
    parameter int CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    i2s_frame_sequencer_if.slave s_if,
    output logic                 bclk,
    output logic                 lrclk,
    output logic                 sdata,
    output logic                 frame_start,
    output logic                 underrun,
    output logic [CNT_W-1:0]     underrun_cnt,
    output logic                 req_irq
);
    localparam int FRAME = 2 * SLOT_W;
    localparam int P_W   = (FRAME > 2) ? $clog2(FRAME) : 1;
    localparam int DIV_W = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(BCLK_DIV / 2 - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
    localparam logic [P_W-1:0]   P_LAST   = P_W'(FRAME - 1);
    localparam logic [P_W-1:0]   P_SLOT   = P_W'(SLOT_W);
    localparam logic [P_W-1:0]   P_LR_ON  = P_W'(SLOT_W - 1);

    typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [P_W-1:0]      p_q, p_d, p_next;
    logic                bclk_q, bclk_d, lrclk_q, lrclk_d, sdata_q, sdata_d;
    logic                fs_q, fs_d, ur_q, ur_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                buf_full_q, buf_full_d;
    logic [SAMPLE_W-1:0] buf_l_q, buf_l_d, buf_r_q, buf_r_d;
    logic [SAMPLE_W-1:0] sh_l_q, sh_l_d, sh_r_q, sh_r_d;
    logic [SAMPLE_W-1:0] ld_l, ld_r;

    logic running, fall, frame_end, stop_now, load, consume, bypass, starve, ready, xfer;

    // A frame boundary in STOP ends the run unless enable came back in time.
    assign running   = (state_q != IDLE);
    assign fall      = running && (div_q == DIV_LAST);
    assign frame_end = fall && (p_q == P_LAST);
    assign stop_now  = frame_end && (state_q == STOP) && !enable;
    assign load      = frame_end && !stop_now;
    assign consume   = load && buf_full_q;
    assign bypass    = load && !buf_full_q && s_if.s_valid;
    assign starve    = load && !buf_full_q && !s_if.s_valid;
    assign ready     = !buf_full_q || consume;
    assign xfer      = s_if.s_valid && ready;
    assign p_next    = (p_q == P_LAST) ? '0 : p_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        p_d        = p_q;
        bclk_d     = bclk_q;
        lrclk_d    = lrclk_q;
        sdata_d    = sdata_q;
        fs_d       = 1'b0;
        ur_d       = 1'b0;
        cnt_d      = cnt_q;
        buf_full_d = buf_full_q;
        buf_l_d    = buf_l_q;
        buf_r_d    = buf_r_q;
        sh_l_d     = sh_l_q;
        sh_r_d     = sh_r_q;
        ld_l       = '0;
        ld_r       = '0;

        case (state_q)
            IDLE: if (enable) begin
                state_d = RUN;
                p_d     = P_LAST;
            end
            RUN:  if (!enable) state_d = STOP;
            STOP: begin
                if (enable)         state_d = RUN;
                else if (frame_end) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (consume) begin
            ld_l = buf_l_q;
            ld_r = buf_r_q;
        end else if (bypass) begin
            ld_l = s_if.s_left;
            ld_r = s_if.s_right;
        end

        if (consume) buf_full_d = 1'b0;
        if (xfer && !bypass) begin
            buf_full_d = 1'b1;
            buf_l_d    = s_if.s_left;
            buf_r_d    = s_if.s_right;
        end

        if (running) begin
            div_d = fall ? '0 : div_q + 1'b1;
            if (div_q == DIV_HALF) bclk_d = 1'b1;
            if (fall) begin
                bclk_d = 1'b0;
                p_d    = p_next;
                if (stop_now) begin
                    lrclk_d = 1'b0;
                    sdata_d = 1'b0;
                end else begin
                    // lrclk runs one bit ahead of the slot it announces.
                    lrclk_d = (p_next >= P_LR_ON) && (p_next != P_LAST);
                    if (load) begin
                        fs_d    = 1'b1;
                        sdata_d = ld_l[SAMPLE_W-1];
                        sh_l_d  = ld_l << 1;
                        sh_r_d  = ld_r;
                        if (starve) begin
                            ur_d = 1'b1;
                            if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                        end
                    end else if (p_next < P_SLOT) begin
                        sdata_d = sh_l_q[SAMPLE_W-1];
                        sh_l_d  = sh_l_q << 1;
                    end else begin
                        sdata_d = sh_r_q[SAMPLE_W-1];
                        sh_r_d  = sh_r_q << 1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            div_q      <= '0;
            p_q        <= '0;
            bclk_q     <= 1'b0;
            lrclk_q    <= 1'b0;
            sdata_q    <= 1'b0;
            fs_q       <= 1'b0;
            ur_q       <= 1'b0;
            cnt_q      <= '0;
            buf_full_q <= 1'b0;
            buf_l_q    <= '0;
            buf_r_q    <= '0;
            sh_l_q     <= '0;
            sh_r_q     <= '0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            p_q        <= p_d;
            bclk_q     <= bclk_d;
            lrclk_q    <= lrclk_d;
            sdata_q    <= sdata_d;
            fs_q       <= fs_d;
            ur_q       <= ur_d;
            cnt_q      <= cnt_d;
            buf_full_q <= buf_full_d;
            buf_l_q    <= buf_l_d;
            buf_r_q    <= buf_r_d;
            sh_l_q     <= sh_l_d;
            sh_r_q     <= sh_r_d;
        end
    end

    assign s_if.s_ready = ready;
    assign bclk         = bclk_q;
    assign lrclk        = lrclk_q;
    assign sdata        = sdata_q;
    assign frame_start  = fs_q;
    assign underrun     = ur_q;
    assign underrun_cnt = cnt_q;
    assign req_irq      = running && !buf_full_q;
endmodule

// File: tb/tb_i2s_frame_sequencer.sv
// Directed bench for i2s_frame_sequencer: default instance plus a CNT_W=2 instance
// for counter saturation.
module tb_i2s_frame_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        enable2 = 1'b0;
    logic        bclk, lrclk, sdata, frame_start, underrun, req_irq;
    logic [15:0] underrun_cnt;
    logic        bclk2, lrclk2, sdata2, fs2, ur2, irq2;
    logic [1:0]  cnt2;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int fs_cnt   = 0;
    int ur_cnt   = 0;
    int ur2_cnt  = 0;
    int fs_cyc   = 0;

    i2s_frame_sequencer_if #(.SAMPLE_W(24)) sif ();
    i2s_frame_sequencer_if #(.SAMPLE_W(24)) sif2 ();

    i2s_frame_sequencer dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .s_if(sif.slave),
        .bclk(bclk), .lrclk(lrclk), .sdata(sdata), .frame_start(frame_start),
        .underrun(underrun), .underrun_cnt(underrun_cnt), .req_irq(req_irq)
    );

    i2s_frame_sequencer #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .enable(enable2), .s_if(sif2.slave),
        .bclk(bclk2), .lrclk(lrclk2), .sdata(sdata2), .frame_start(fs2),
        .underrun(ur2), .underrun_cnt(cnt2), .req_irq(irq2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (frame_start === 1'b1) fs_cnt <= fs_cnt + 1;
        if (underrun === 1'b1)    ur_cnt <= ur_cnt + 1;
        if (ur2 === 1'b1)         ur2_cnt <= ur2_cnt + 1;
    end

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Collects one frame, one bit per bclk-high phase, MSB of the vector = p0.
    task automatic capture_frame(input bit have_fs, input int drop_p, input int abort_p,
                                 output logic [63:0] sd, output logic [63:0] lr, output bit ok);
        int guard;
        sd = '0;
        lr = '0;
        ok = 1'b1;
        if (!have_fs) begin
            guard = 0;
            while (frame_start !== 1'b1 && guard < 600) begin
                @(negedge clk);
                guard++;
            end
            if (frame_start !== 1'b1) begin
                ok = 1'b0;
                return;
            end
        end
        fs_cyc = cyc;
        for (int p = 0; p < 64; p++) begin
            guard = 0;
            while (bclk !== 1'b1 && guard < 20) begin
                @(negedge clk);
                guard++;
            end
            if (bclk !== 1'b1) begin
                ok = 1'b0;
                return;
            end
            sd[63-p] = sdata;
            lr[63-p] = lrclk;
            if (p == drop_p) enable = 1'b0;
            if (p == abort_p) return;
            if (p < 63) begin
                guard = 0;
                while (bclk !== 1'b0 && guard < 20) begin
                    @(negedge clk);
                    guard++;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_checks++;
        if ({bclk, lrclk, sdata, frame_start, underrun, req_irq} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b, want 000000",
                     {bclk, lrclk, sdata, frame_start, underrun, req_irq});
        end
        n_checks++;
        if (underrun_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_cnt: got %0d, want 0", underrun_cnt);
        end
        n_checks++;
        if (sif.s_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %b, want 1", sif.s_ready);
        end
        do_reset();
    endtask

    task automatic test_underrun();
        logic [63:0] sd, lr;
        logic [63:0] sd_or;
        bit ok, all_ok;
        int ur0;
        sd_or = '0;
        all_ok = 1'b1;
        sif.s_valid = 1'b0;
        ur0 = ur_cnt;
        enable = 1'b1;
        for (int f = 0; f < 3; f++) begin
            capture_frame(1'b0, -1, -1, sd, lr, ok);
            sd_or = sd_or | sd;
            all_ok = all_ok & ok;
        end
        n_checks++;
        if (all_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL underrun_frames: timeout got %b, want 1", all_ok);
        end
        n_checks++;
        if (sd_or !== 64'h0) begin
            n_fail++;
            $display("FAIL underrun_sdata: got %h, want 0", sd_or);
        end
        n_checks++;
        if (req_irq !== 1'b1) begin
            n_fail++;
            $display("FAIL underrun_irq: got %b, want 1", req_irq);
        end
        enable = 1'b0;
        repeat (10) @(negedge clk);
        n_checks++;
        if (ur_cnt - ur0 !== 3) begin
            n_fail++;
            $display("FAIL underrun_pulses: got %0d, want 3", ur_cnt - ur0);
        end
        n_checks++;
        if (underrun_cnt !== 16'd3) begin
            n_fail++;
            $display("FAIL underrun_cnt: got %0d, want 3", underrun_cnt);
        end
        n_checks++;
        if (req_irq !== 1'b0) begin
            n_fail++;
            $display("FAIL underrun_idle_irq: got %b, want 0", req_irq);
        end
    endtask

    task automatic test_normal();
        logic [63:0] sd1, lr1, sd2, lr2;
        bit ok1, ok2;
        int c1, ur0;
        sif.s_left  = 24'hABCDEF;
        sif.s_right = 24'h123456;
        sif.s_valid = 1'b1;
        ur0 = ur_cnt;
        enable = 1'b1;
        capture_frame(1'b0, -1, -1, sd1, lr1, ok1);
        c1 = fs_cyc;
        capture_frame(1'b0, -1, -1, sd2, lr2, ok2);
        n_checks++;
        if ({ok1, ok2} !== 2'b11) begin
            n_fail++;
            $display("FAIL normal_timeout: got %b, want 11", {ok1, ok2});
        end
        n_checks++;
        if (sd1 !== 64'hABCDEF00_12345600) begin
            n_fail++;
            $display("FAIL normal_sdata1: got %h, want abcdef0012345600", sd1);
        end
        n_checks++;
        if (lr1 !== 64'h00000001_FFFFFFFE) begin
            n_fail++;
            $display("FAIL normal_lrclk: got %h, want 00000001fffffffe", lr1);
        end
        n_checks++;
        if (sd2 !== 64'hABCDEF00_12345600) begin
            n_fail++;
            $display("FAIL normal_sdata2: got %h, want abcdef0012345600", sd2);
        end
        n_checks++;
        if (fs_cyc - c1 !== 256) begin
            n_fail++;
            $display("FAIL normal_period: got %0d, want 256", fs_cyc - c1);
        end
        n_checks++;
        if (ur_cnt - ur0 !== 0 || underrun_cnt !== 16'd3) begin
            n_fail++;
            $display("FAIL normal_no_underrun: got pulses %0d cnt %0d, want 0 and 3",
                     ur_cnt - ur0, underrun_cnt);
        end
    endtask

    task automatic test_stop();
        logic [63:0] sd, lr;
        bit ok;
        logic act;
        int fs0;
        act = 1'b0;
        capture_frame(1'b0, 10, -1, sd, lr, ok);
        fs0 = fs_cnt;
        n_checks++;
        if (ok !== 1'b1 || sd !== 64'hABCDEF00_12345600) begin
            n_fail++;
            $display("FAIL stop_last_frame: got %h ok %b, want abcdef0012345600 ok 1", sd, ok);
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 300; i++) begin
            act = act | bclk | lrclk | sdata;
            @(negedge clk);
        end
        n_checks++;
        if (act !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_idle_lines: got activity %b, want 0", act);
        end
        n_checks++;
        if (fs_cnt - fs0 !== 0) begin
            n_fail++;
            $display("FAIL stop_frame_start: got %0d, want 0", fs_cnt - fs0);
        end
        n_checks++;
        if (req_irq !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_irq: got %b, want 0", req_irq);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [63:0] sd, lr;
        logic [4:0] bv, fv;
        bit ok;
        enable = 1'b1;
        capture_frame(1'b0, -1, 40, sd, lr, ok);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (ok !== 1'b1 || {bclk, lrclk, sdata, frame_start, underrun, req_irq} !== 6'b0
            || underrun_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL rst_mid_outputs: got %b cnt %0d ok %b, want 000000 cnt 0 ok 1",
                     {bclk, lrclk, sdata, frame_start, underrun, req_irq}, underrun_cnt, ok);
        end
        enable = 1'b0;
        sif.s_valid = 1'b0;
        #3 rst_n = 1'b1;
        @(negedge clk);
        enable = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            bv[k-1] = bclk;
            fv[k-1] = frame_start;
        end
        n_checks++;
        if (bv !== 5'b01100) begin
            n_fail++;
            $display("FAIL rst_restart_bclk: got %b, want 01100", bv);
        end
        n_checks++;
        if (fv !== 5'b10000) begin
            n_fail++;
            $display("FAIL rst_restart_load: got %b, want 10000", fv);
        end
        enable = 1'b0;
    endtask

    task automatic test_bypass();
        logic [63:0] sd, lr;
        bit ok1, ok2;
        int ur0;
        sif.s_valid = 1'b0;
        do_reset();
        enable = 1'b1;
        capture_frame(1'b0, -1, -1, sd, lr, ok1);
        @(negedge clk);
        sif.s_left  = 24'h5A5A5A;
        sif.s_right = 24'hC3C3C3;
        sif.s_valid = 1'b1;
        @(negedge clk);
        ur0 = ur_cnt;
        n_checks++;
        if ({frame_start, underrun, sif.s_ready} !== 3'b101) begin
            n_fail++;
            $display("FAIL bypass_load: got fs/ur/rdy %b, want 101",
                     {frame_start, underrun, sif.s_ready});
        end
        n_checks++;
        if (underrun_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL bypass_cnt: got %0d, want 1", underrun_cnt);
        end
        sif.s_valid = 1'b0;
        capture_frame(1'b1, -1, -1, sd, lr, ok2);
        n_checks++;
        if ({ok1, ok2} !== 2'b11 || sd !== 64'h5A5A5A00_C3C3C300) begin
            n_fail++;
            $display("FAIL bypass_sdata: got %h ok %b, want 5a5a5a00c3c3c300 ok 11", sd, {ok1, ok2});
        end
        n_checks++;
        if (ur_cnt - ur0 !== 0 || sif.s_ready !== 1'b1 || req_irq !== 1'b1) begin
            n_fail++;
            $display("FAIL bypass_after: got ur %0d rdy %b irq %b, want 0 1 1",
                     ur_cnt - ur0, sif.s_ready, req_irq);
        end
        enable = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_cnt_saturate();
        int ur0;
        do_reset();
        ur0 = ur2_cnt;
        enable2 = 1'b1;
        repeat (800) @(negedge clk);
        n_checks++;
        if (ur2_cnt - ur0 !== 4 || cnt2 !== 2'd3) begin
            n_fail++;
            $display("FAIL sat_four: got pulses %0d cnt %0d, want 4 and 3", ur2_cnt - ur0, cnt2);
        end
        repeat (240) @(negedge clk);
        n_checks++;
        if (ur2_cnt - ur0 !== 5) begin
            n_fail++;
            $display("FAIL sat_pulses: got %0d, want 5", ur2_cnt - ur0);
        end
        n_checks++;
        if (cnt2 !== 2'd3) begin
            n_fail++;
            $display("FAIL sat_cnt: got %0d, want 3", cnt2);
        end
        enable2 = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        sif.s_valid  = 1'b0;
        sif.s_left   = '0;
        sif.s_right  = '0;
        sif2.s_valid = 1'b0;
        sif2.s_left  = '0;
        sif2.s_right = '0;
        test_reset();
        test_underrun();
        test_normal();
        test_stop();
        test_reset_mid_frame();
        test_bypass();
        test_cnt_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
